// File: rtl/usb_ep_handshake_ctrl.sv
// USB single-endpoint transaction sequencer: ACK/NAK for OUT, DATA for IN, timeouts and retries.
// Optional DATA0/DATA1 toggle tracking is enabled by defining DATA_TOGGLE_EN.
module usb_ep_handshake_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned BUF_DEPTH      = 64,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] rx_packet,
    input  logic       rx_data_ready,
    input  logic       rx_error,
    input  logic       tx_transfer_active,
    input  logic       tx_error,
    input  logic [6:0] buffer_occupancy,
    input  logic       in_data_valid,
    output logic       tx_start,
    output logic [1:0] tx_packet,
    output logic       flush,
    output logic       out_done,
    output logic       in_done,
    output logic       in_fail,
    output logic       busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RC_W = $clog2(MAX_RETRY + 1);

    localparam logic [2:0] PID_OUT   = 3'd1;
    localparam logic [2:0] PID_IN    = 3'd2;
    localparam logic [2:0] PID_DATA0 = 3'd3;
    localparam logic [2:0] PID_DATA1 = 3'd4;
    localparam logic [2:0] PID_ACK   = 3'd5;

    localparam logic [1:0] TX_DATA0 = 2'd0;
    localparam logic [1:0] TX_DATA1 = 2'd1;
    localparam logic [1:0] TX_ACK   = 2'd2;
    localparam logic [1:0] TX_NAK   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        OUT_WAIT,
        HS_SEND,
        HS_WAIT,
        IN_SEND,
        IN_TXWAIT,
        ACK_WAIT
    } state_t;

    state_t            state, state_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic [RC_W-1:0]   retry_cnt, retry_n;
    logic              tx_active_q;
    logic              ack_pend, ack_pend_n;
    logic              tx_start_n, flush_n, out_done_n, in_done_n, in_fail_n;
    logic [1:0]        tx_packet_n;
    logic              fail_attempt;
    logic              rx_ok, is_data, tx_done, timeout;
    logic              pid_match;
    logic [1:0]        in_pid;

`ifdef DATA_TOGGLE_EN
    logic out_toggle, out_toggle_n;
    logic in_toggle, in_toggle_n;
    assign pid_match = (rx_packet == (out_toggle ? PID_DATA1 : PID_DATA0));
    assign in_pid    = in_toggle ? TX_DATA1 : TX_DATA0;
`else
    assign pid_match = 1'b1;
    assign in_pid    = TX_DATA0;
`endif

    assign rx_ok   = rx_data_ready & ~rx_error;
    assign is_data = (rx_packet == PID_DATA0) | (rx_packet == PID_DATA1);
    // Transmitter completion is the falling edge of its busy flag.
    assign tx_done = tx_active_q & ~tx_transfer_active;
    assign timeout = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            retry_cnt   <= '0;
            tx_active_q <= 1'b0;
            ack_pend    <= 1'b0;
            tx_start    <= 1'b0;
            tx_packet   <= TX_NAK;
            flush       <= 1'b0;
            out_done    <= 1'b0;
            in_done     <= 1'b0;
            in_fail     <= 1'b0;
            busy        <= 1'b0;
`ifdef DATA_TOGGLE_EN
            out_toggle  <= 1'b0;
            in_toggle   <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            to_cnt      <= to_cnt_n;
            retry_cnt   <= retry_n;
            tx_active_q <= tx_transfer_active;
            ack_pend    <= ack_pend_n;
            tx_start    <= tx_start_n;
            tx_packet   <= tx_packet_n;
            flush       <= flush_n;
            out_done    <= out_done_n;
            in_done     <= in_done_n;
            in_fail     <= in_fail_n;
            busy        <= (state_n != IDLE);
`ifdef DATA_TOGGLE_EN
            out_toggle  <= out_toggle_n;
            in_toggle   <= in_toggle_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        to_cnt_n     = to_cnt;
        retry_n      = retry_cnt;
        ack_pend_n   = ack_pend;
        tx_start_n   = 1'b0;
        tx_packet_n  = tx_packet;
        flush_n      = 1'b0;
        out_done_n   = 1'b0;
        in_done_n    = 1'b0;
        in_fail_n    = 1'b0;
        fail_attempt = 1'b0;
`ifdef DATA_TOGGLE_EN
        out_toggle_n = out_toggle;
        in_toggle_n  = in_toggle;
`endif

        // Start pulses are issued on entry to HS_SEND/IN_SEND so the registered
        // tx_start lines up with the one cycle spent in those states.
        unique case (state)
            IDLE: begin
                if (rx_ok && rx_packet == PID_OUT) begin
                    state_n  = OUT_WAIT;
                    to_cnt_n = '0;
                end else if (rx_ok && rx_packet == PID_IN) begin
                    tx_start_n = 1'b1;
                    if (in_data_valid && buffer_occupancy != 7'd0) begin
                        state_n     = IN_SEND;
                        tx_packet_n = in_pid;
                    end else begin
                        state_n     = HS_SEND;
                        tx_packet_n = TX_NAK;
                        ack_pend_n  = 1'b0;
                    end
                end
            end
            OUT_WAIT: begin
                to_cnt_n = to_cnt + 1'b1;
                if (rx_ok && is_data) begin
                    state_n    = HS_SEND;
                    tx_start_n = 1'b1;
                    ack_pend_n = 1'b0;
                    if (buffer_occupancy == 7'(BUF_DEPTH)) begin
                        tx_packet_n = TX_NAK;
                        flush_n     = 1'b1;
                    end else begin
                        tx_packet_n = TX_ACK;
                        if (pid_match) ack_pend_n = 1'b1;
                        else           flush_n    = 1'b1;
                    end
                end else if (rx_data_ready || rx_error || timeout) begin
                    state_n = IDLE;
                    flush_n = 1'b1;
                end
            end
            HS_SEND: state_n = HS_WAIT;
            HS_WAIT: begin
                if (tx_error) begin
                    state_n = IDLE;
                end else if (tx_done) begin
                    state_n    = IDLE;
                    out_done_n = ack_pend;
`ifdef DATA_TOGGLE_EN
                    if (ack_pend) out_toggle_n = ~out_toggle;
`endif
                end
            end
            IN_SEND: state_n = IN_TXWAIT;
            IN_TXWAIT: begin
                if (tx_error) begin
                    state_n      = IDLE;
                    fail_attempt = 1'b1;
                end else if (tx_done) begin
                    state_n  = ACK_WAIT;
                    to_cnt_n = '0;
                end
            end
            ACK_WAIT: begin
                to_cnt_n = to_cnt + 1'b1;
                if (rx_ok && rx_packet == PID_ACK) begin
                    state_n   = IDLE;
                    in_done_n = 1'b1;
                    retry_n   = '0;
`ifdef DATA_TOGGLE_EN
                    in_toggle_n = ~in_toggle;
`endif
                end else if (rx_data_ready || rx_error || timeout) begin
                    state_n      = IDLE;
                    fail_attempt = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (fail_attempt) begin
            if (retry_cnt == RC_W'(MAX_RETRY - 1)) begin
                in_fail_n = 1'b1;
                flush_n   = 1'b1;
                retry_n   = '0;
            end else begin
                retry_n = retry_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_ep_handshake_ctrl.sv
// Directed self-checking bench for usb_ep_handshake_ctrl (TIMEOUT_CYCLES=16).
// Expected values track DATA_TOGGLE_EN when the macro is defined for the build.
module tb_usb_ep_handshake_ctrl;

`ifdef DATA_TOGGLE_EN
    localparam int unsigned TOG = 1;
`else
    localparam int unsigned TOG = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rx_packet;
    logic       rx_data_ready;
    logic       rx_error;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [6:0] buffer_occupancy;
    logic       in_data_valid;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       flush;
    logic       out_done;
    logic       in_done;
    logic       in_fail;
    logic       busy;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned c_start;
    int unsigned n;

    usb_ep_handshake_ctrl #(
        .TIMEOUT_CYCLES(16),
        .BUF_DEPTH     (64),
        .MAX_RETRY     (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rx_packet         (rx_packet),
        .rx_data_ready     (rx_data_ready),
        .rx_error          (rx_error),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error),
        .buffer_occupancy  (buffer_occupancy),
        .in_data_valid     (in_data_valid),
        .tx_start          (tx_start),
        .tx_packet         (tx_packet),
        .flush             (flush),
        .out_done          (out_done),
        .in_done           (in_done),
        .in_fail           (in_fail),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c_start += 32'(tx_start);
    endtask

    task automatic send(input logic [2:0] pid, input logic err);
        rx_packet     = pid;
        rx_error      = err;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        rx_error      = 1'b0;
        rx_packet     = 3'd0;
    endtask

    task automatic tx_run(input int unsigned len);
        tx_transfer_active = 1'b1;
        repeat (len) tick();
        tx_transfer_active = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rx_packet = 3'd0; rx_data_ready = 1'b0; rx_error = 1'b0;
        tx_transfer_active = 1'b0; tx_error = 1'b0; buffer_occupancy = 7'd0;
        in_data_valid = 1'b0; c_start = 0;
        repeat (3) tick();
        check_val("rst_tx_start", 32'(tx_start), 0);
        check_val("rst_tx_packet", 32'(tx_packet), 3);
        check_val("rst_pulses", {flush, out_done, in_done, in_fail}, 0);
        check_val("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // OUT / DATA0 accepted with ACK
        c_start = 0;
        send(3'd1, 1'b0);
        check_val("out_busy", 32'(busy), 1);
        repeat (4) tick();
        buffer_occupancy = 7'd8;
        send(3'd3, 1'b0);
        check_val("out_start", 32'(tx_start), 1);
        check_val("out_pkt", 32'(tx_packet), 2);
        check_val("out_noflush", 32'(flush), 0);
        tick();
        check_val("out_start_1cyc", 32'(tx_start), 0);
        tx_transfer_active = 1'b1;
        repeat (3) tick();
        check_val("out_pkt_held", 32'(tx_packet), 2);
        check_val("out_done_early", 32'(out_done), 0);
        tx_transfer_active = 1'b0;
        tick();
        check_val("out_done", 32'(out_done), 1);
        check_val("out_idle", 32'(busy), 0);
        tick();
        check_val("out_done_1cyc", 32'(out_done), 0);
        check_val("out_start_cnt", c_start, 1);

        // IN with payload, ACKed
        in_data_valid = 1'b1; buffer_occupancy = 7'd16;
        send(3'd2, 1'b0);
        check_val("in_start", 32'(tx_start), 1);
        check_val("in_pkt", 32'(tx_packet), 0);
        tick();
        tx_run(4);
        check_val("in_ackwait_busy", 32'(busy), 1);
        repeat (8) tick();
        send(3'd5, 1'b0);
        check_val("in_done", 32'(in_done), 1);
        check_val("in_nofail", 32'(in_fail), 0);
        check_val("in_idle", 32'(busy), 0);

        // IN with no payload -> NAK
        in_data_valid = 1'b0;
        send(3'd2, 1'b0);
        check_val("nak_start", 32'(tx_start), 1);
        check_val("nak_pkt", 32'(tx_packet), 3);
        tick();
        tx_run(2);
        check_val("nak_pulses", {out_done, in_done, in_fail, flush}, 0);
        check_val("nak_idle", 32'(busy), 0);

        // Three IN attempts timing out in ACK_WAIT
        in_data_valid = 1'b1;
        for (int unsigned a = 1; a <= 3; a++) begin
            send(3'd2, 1'b0);
            check_val($sformatf("to%0d_pkt", a), 32'(tx_packet), TOG);
            tick();
            tx_run(2);
            wait_idle();
            check_val($sformatf("to%0d_cycles", a), n, 16);
            check_val($sformatf("to%0d_in_fail", a), 32'(in_fail), (a == 3) ? 1 : 0);
            check_val($sformatf("to%0d_flush", a), 32'(flush), (a == 3) ? 1 : 0);
            tick();
        end
        in_data_valid = 1'b0;

        // OUT followed by DATA1 with receive error
        c_start = 0;
        send(3'd1, 1'b0);
        send(3'd4, 1'b1);
        check_val("rxerr_flush", 32'(flush), 1);
        check_val("rxerr_idle", 32'(busy), 0);
        tick();
        check_val("rxerr_flush_1cyc", 32'(flush), 0);
        check_val("rxerr_nostart", c_start, 0);

        // OUT with full buffer -> NAK plus flush
        buffer_occupancy = 7'd64;
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        check_val("full_start", 32'(tx_start), 1);
        check_val("full_pkt", 32'(tx_packet), 3);
        check_val("full_flush", 32'(flush), 1);
        tick();
        tx_run(2);
        check_val("full_no_out_done", 32'(out_done), 0);
        check_val("full_idle", 32'(busy), 0);

        // OUT with no data phase times out
        send(3'd1, 1'b0);
        wait_idle();
        check_val("outto_cycles", n, 16);
        check_val("outto_flush", 32'(flush), 1);
        tick();

        // Toggle sequence from a clean reset
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        buffer_occupancy = 7'd8;
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        check_val("tg1_pkt", 32'(tx_packet), 2);
        check_val("tg1_flush", 32'(flush), 0);
        tick();
        tx_run(2);
        check_val("tg1_out_done", 32'(out_done), 1);
        tick();
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        check_val("tg2_pkt", 32'(tx_packet), 2);
        check_val("tg2_flush", 32'(flush), TOG);
        tick();
        tx_run(2);
        check_val("tg2_out_done", 32'(out_done), 1 - TOG);
        tick();
        in_data_valid = 1'b1; buffer_occupancy = 7'd16;
        for (int unsigned k = 0; k < 2; k++) begin
            send(3'd2, 1'b0);
            check_val($sformatf("tgin%0d_pkt", k), 32'(tx_packet), k * TOG);
            tick();
            tx_run(3);
            repeat (3) tick();
            send(3'd5, 1'b0);
            check_val($sformatf("tgin%0d_done", k), 32'(in_done), 1);
        end
        in_data_valid = 1'b0;

        // Reset in HS_WAIT
        buffer_occupancy = 7'd8;
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        tick();
        tx_transfer_active = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check_val("rstmid_busy", 32'(busy), 0);
        check_val("rstmid_outs", {tx_start, flush, out_done, in_done, in_fail}, 0);
        check_val("rstmid_pkt", 32'(tx_packet), 3);
        rst = 1'b0;
        tx_transfer_active = 1'b0;
        tick();
        check_val("rstmid_no_done", 32'(out_done), 0);
        check_val("rstmid_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
